// File: rtl/vend_pkg.sv
// Shared vending constants: coin codes, coin values, acceptor state encoding.
package vend_pkg;
    localparam int CREDIT_W_DEF = 9;

    localparam logic [1:0] COIN_SLUG    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam int VAL_NICKEL  = 5;
    localparam int VAL_DIME    = 10;
    localparam int VAL_QUARTER = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_RETURN
    } state_e;
endpackage

// File: rtl/coin_acceptor_if.sv
// Coin / purchase / change-handshake bundle between the vending front end and its environment.
interface coin_acceptor_if #(
    parameter int CREDIT_W = vend_pkg::CREDIT_W_DEF
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                coin_accept;
    logic                coin_reject;
    logic [CREDIT_W-1:0] price;
    logic                vend_req;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                vend;
    logic                insufficient;
    logic [CREDIT_W-1:0] change;
    logic                change_valid;
    logic                change_ack;

    modport slave (
        input  coin_valid, coin_type, price, vend_req, cancel, change_ack,
        output coin_accept, coin_reject, credit, vend, insufficient, change, change_valid
    );

    modport master (
        output coin_valid, coin_type, price, vend_req, cancel, change_ack,
        input  coin_accept, coin_reject, credit, vend, insufficient, change, change_valid
    );
endinterface

// File: rtl/coin_value_decoder.sv
// Combinational coin code to cent value; slugs decode to zero with valid low.
module coin_value_decoder
    import vend_pkg::*;
#(
    parameter int CREDIT_W = CREDIT_W_DEF
) (
    input  logic [1:0]          coin_type,
    output logic [CREDIT_W-1:0] value,
    output logic                valid
);
    always_comb begin
        value = '0;
        valid = 1'b1;
        case (coin_type)
            COIN_NICKEL:  value = CREDIT_W'(VAL_NICKEL);
            COIN_DIME:    value = CREDIT_W'(VAL_DIME);
            COIN_QUARTER: value = CREDIT_W'(VAL_QUARTER);
            default:      valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/coin_acceptor.sv
// Coin credit accumulator: credits coins, charges purchases, hands change to the dispenser.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 495,
    parameter int CREDIT_W   = CREDIT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    coin_acceptor_if.slave  bus
);
    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                change_valid_q, change_valid_d;
    logic                vend_q, vend_d;
    logic                insufficient_q, insufficient_d;
    logic                coin_accept_q, coin_accept_d;
    logic                coin_reject_q, coin_reject_d;

    logic [CREDIT_W-1:0] coin_val;
    logic                coin_ok;
    logic [CREDIT_W:0]   sum;

    coin_value_decoder #(.CREDIT_W(CREDIT_W)) u_dec (
        .coin_type (bus.coin_type),
        .value     (coin_val),
        .valid     (coin_ok)
    );

    // One extra bit so credit + coin never wraps before the limit check.
    assign sum = {1'b0, credit_q} + {1'b0, coin_val};

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        change_valid_d = change_valid_q;
        vend_d         = 1'b0;
        insufficient_d = 1'b0;
        coin_accept_d  = 1'b0;
        coin_reject_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (bus.cancel && credit_q != '0) begin
                    change_d       = credit_q;
                    credit_d       = '0;
                    change_valid_d = 1'b1;
                    state_d        = ST_RETURN;
                    coin_reject_d  = bus.coin_valid;
                end else if (bus.vend_req) begin
                    coin_reject_d = bus.coin_valid;
                    if (bus.price != '0 && credit_q >= bus.price) begin
                        change_d = credit_q - bus.price;
                        credit_d = '0;
                        vend_d   = 1'b1;
                        state_d  = ST_VEND;
                    end else begin
                        insufficient_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (coin_ok && sum <= MAX_C) begin
                        credit_d      = sum[CREDIT_W-1:0];
                        coin_accept_d = 1'b1;
                        state_d       = ST_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = bus.coin_valid;
                if (change_q != '0) begin
                    change_valid_d = 1'b1;
                    state_d        = ST_RETURN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RETURN: begin
                coin_reject_d = bus.coin_valid;
                if (bus.change_ack && change_valid_q) begin
                    change_valid_d = 1'b0;
                    change_d       = '0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            vend_q         <= 1'b0;
            insufficient_q <= 1'b0;
            coin_accept_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            vend_q         <= vend_d;
            insufficient_q <= insufficient_d;
            coin_accept_q  <= coin_accept_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.change       = change_q;
    assign bus.change_valid = change_valid_q;
    assign bus.vend         = vend_q;
    assign bus.insufficient = insufficient_q;
    assign bus.coin_accept  = coin_accept_q;
    assign bus.coin_reject  = coin_reject_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random traffic against a cents-level model.
module tb_coin_acceptor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    coin_acceptor_if #(.CREDIT_W(9)) bus ();

    coin_acceptor #(.MAX_CREDIT(495), .CREDIT_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: the customer's money in cents plus where the purchase stands.
    int  m_credit, m_change;
    bit  m_cv, m_vending, m_returning;
    bit  e_acc, e_rej, e_vend, e_ins;

    function automatic int cents(input logic [1:0] t);
        case (t)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".credit"}, int'(bus.credit), m_credit);
        chk({tag, ".change"}, int'(bus.change), m_change);
        chk({tag, ".cv"},     int'(bus.change_valid), int'(m_cv));
        chk({tag, ".vend"},   int'(bus.vend), int'(e_vend));
        chk({tag, ".ins"},    int'(bus.insufficient), int'(e_ins));
        chk({tag, ".acc"},    int'(bus.coin_accept), int'(e_acc));
        chk({tag, ".rej"},    int'(bus.coin_reject), int'(e_rej));
    endtask

    task automatic model_reset();
        m_credit = 0; m_change = 0; m_cv = 0; m_vending = 0; m_returning = 0;
        e_acc = 0; e_rej = 0; e_vend = 0; e_ins = 0;
    endtask

    task automatic cyc(input string tag, input bit cv, input logic [1:0] ct, input bit vr,
                       input int pr, input bit cn, input bit ack);
        int v;
        bus.coin_valid = cv; bus.coin_type = ct; bus.vend_req = vr;
        bus.price = 9'(pr); bus.cancel = cn; bus.change_ack = ack;
        e_acc = 0; e_rej = 0; e_vend = 0; e_ins = 0;
        if (m_vending) begin
            m_vending = 0;
            e_rej = cv;
            if (m_change != 0) begin m_cv = 1; m_returning = 1; end
        end else if (m_returning) begin
            e_rej = cv;
            if (ack && m_cv) begin m_cv = 0; m_change = 0; m_returning = 0; end
        end else if (cn && m_credit > 0) begin
            m_change = m_credit; m_credit = 0; m_cv = 1; m_returning = 1; e_rej = cv;
        end else if (vr) begin
            e_rej = cv;
            if (pr != 0 && m_credit >= pr) begin
                m_change = m_credit - pr; m_credit = 0; m_vending = 1; e_vend = 1;
            end else e_ins = 1;
        end else if (cv) begin
            v = cents(ct);
            if (v != 0 && m_credit + v <= 495) begin m_credit += v; e_acc = 1; end
            else e_rej = 1;
        end
        @(posedge clk); #1;
        chk_all(tag);
    endtask

    task automatic coin(input string tag, input logic [1:0] ct);
        cyc(tag, 1, ct, 0, 0, 0, 0);
    endtask

    task automatic idle(input string tag, input bit ack);
        cyc(tag, 0, 2'b00, 0, 0, 0, ack);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        chk_all({tag, ".async"});
        @(posedge clk); #1 rst = 1'b0;
        chk_all({tag, ".post"});
    endtask

    initial begin
        bus.coin_valid = 0; bus.coin_type = 0; bus.vend_req = 0;
        bus.price = 0; bus.cancel = 0; bus.change_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_all("reset");
        rst = 1'b0;

        // Quarter, quarter, dime, buy at 50 -> 10 change held until ack.
        coin("q1", 2'b11); chk("q1.val", int'(bus.credit), 25);
        coin("q2", 2'b11); chk("q2.val", int'(bus.credit), 50);
        coin("d1", 2'b10); chk("d1.val", int'(bus.credit), 60);
        cyc("buy50", 0, 0, 1, 50, 0, 0);
        chk("buy50.vend", int'(bus.vend), 1);
        idle("vend.after", 0);
        chk("chg10", int'(bus.change), 10);
        repeat (4) idle("hold", 0);
        idle("ack", 1);
        chk("ack.cv", int'(bus.change_valid), 0);

        // Fill to the limit, then probe the boundary.
        repeat (19) coin("fill", 2'b11);
        chk("fill.val", int'(bus.credit), 475);
        coin("over", 2'b11);
        chk("over.rej", int'(bus.coin_reject), 1);
        coin("nick", 2'b01);
        chk("nick.val", int'(bus.credit), 480);
        coin("slug", 2'b00);
        cyc("cxl480", 0, 0, 0, 0, 1, 0);
        idle("cxl.ack", 1);

        // Insufficient credit.
        coin("a25", 2'b11); coin("a5", 2'b01);
        cyc("short", 0, 0, 1, 50, 0, 0);
        chk("short.ins", int'(bus.insufficient), 1);
        cyc("price0", 0, 0, 1, 0, 0, 0);

        // Cancel beats vend_req and a coin in the same cycle.
        coin("b5", 2'b01);
        cyc("triple", 1, 2'b10, 1, 25, 1, 0);
        chk("triple.chg", int'(bus.change), 35);
        idle("triple.ack", 1);
        idle("ack.ignored", 1);

        // Exact payment: no change phase.
        coin("e1", 2'b11); coin("e2", 2'b11);
        cyc("exact", 0, 0, 1, 50, 0, 0);
        idle("exact.v", 0); idle("exact.i", 0);
        chk("exact.cv", int'(bus.change_valid), 0);

        // Reset while change is pending.
        coin("r1", 2'b10);
        cyc("rcxl", 0, 0, 0, 0, 1, 0);
        async_reset("rst.ret");
        coin("resume", 2'b01);
        chk("resume.val", int'(bus.credit), 5);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) async_reset("rnd.rst");
            else cyc("rnd", $urandom_range(1) == 1, 2'($urandom_range(3)),
                     $urandom_range(9) == 0, 5 * $urandom_range(20),
                     $urandom_range(19) == 0, $urandom_range(3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front end of the vending datapath; works in the opposite direction to the change dispenser. It converts inserted coins into a running credit total. On a purchase it charges the price and emits the remaining change amount, in cents, to the downstream dispenser through a valid/ack handshake. A cancel request refunds the full credit the same way.

## Interface
- `MAX_CREDIT`, default 495: maximum credit in cents, a multiple of 5. Any coin that would exceed it is rejected.
- `CREDIT_W`, default 9: width of credit, price and change. Must hold `MAX_CREDIT`.
- `clk`  input  1  — system clock; all state updates on the rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `coin_valid`  input  1  — coin present this cycle.
- `coin_type`  input  2  — coin code: 00 slug/invalid, 01 nickel, 10 dime, 11 quarter.
- `coin_accept`  output  1  — one-cycle pulse: coin credited.
- `coin_reject`  output  1  — one-cycle pulse: coin returned to the customer.
- `price`  input  CREDIT_W  — item price in cents; sampled with `vend_req`.
- `vend_req`  input  1  — purchase request.
- `cancel`  input  1  — refund request.
- `credit`  output  CREDIT_W  — current credit, registered.
- `vend`  output  1  — one-cycle pulse: release the item.
- `insufficient`  output  1  — one-cycle pulse: `vend_req` was refused.
- `change`  output  CREDIT_W  — amount for the dispenser; stable while `change_valid` is high.
- `change_valid`  output  1  — change is pending.
- `change_ack`  input  1  — dispenser has taken the change.

## Operation
- **States:**
  - IDLE: credit is 0.
  - COLLECT: credit > 0.
  - VEND: one cycle.
  - RETURN: waiting for `change_ack`.
- **Coin values:** nickel 5, dime 10, quarter 25, slug 0.
- **Coin acceptance:** a coin is accepted only when all of these hold:
  - state is IDLE or COLLECT;
  - the code is not a slug;
  - `credit + value <= MAX_CREDIT`;
  - no `cancel` or `vend_req` acts in the same cycle.
- **Coin result:** accepted → credit += value and `coin_accept` pulses. Otherwise → `coin_reject` pulses and credit is unchanged.
- **Request priority in IDLE/COLLECT:** `cancel` > `vend_req` > coin.
  - `cancel` with credit > 0: `change` := credit, credit := 0, go to RETURN. With credit = 0, `cancel` is ignored.
  - `vend_req` with `price != 0` and `credit >= price`: `change` := credit − price, credit := 0, go to VEND.
  - `vend_req` with `credit < price` or `price == 0`: `insufficient` pulses; state and credit are unchanged.
- **VEND:** `vend` = 1 for exactly one cycle. Then go to RETURN if `change != 0`, else to IDLE.
- **RETURN:**
  - `change_valid` = 1 and `change` holds.
  - All coins are rejected; `vend_req` and `cancel` are ignored.
  - `change_ack` while `change_valid` = 1 → `change_valid` := 0, `change` := 0, go to IDLE.
- **Arithmetic:** unsigned, CREDIT_W bits. Compare the sum in CREDIT_W+1 bits so it cannot wrap. Subtraction is performed only after `credit >= price` is confirmed.
- **Reset (asserted at any time, including mid-VEND or mid-RETURN):**
  - state → IDLE;
  - `credit`, `change`, `change_valid`, `vend`, `insufficient`, `coin_accept`, `coin_reject` all → 0;
  - pending credit is discarded.

## Timing
- All outputs are registered.
- Coin presented at edge N: `coin_accept`/`coin_reject` and the updated `credit` are visible after edge N, for one cycle.
- `vend_req` accepted at edge N:
  - after edge N: VEND, `vend` = 1, `credit` = 0;
  - after edge N+1: `change_valid` = 1 if change is nonzero.
- `cancel` accepted at edge N: `change_valid` = 1 and `credit` = 0 after edge N.
- `change_ack` sampled at edge M: `change_valid` = 0 after edge M. A new coin can be accepted at edge M+1.
- `change_ack` while `change_valid` = 0 is ignored.
- Throughput: one coin per cycle in IDLE/COLLECT.

## Structure
- Package `vend_pkg` holds:
  - coin code constants (`COIN_SLUG`, `COIN_NICKEL`, `COIN_DIME`, `COIN_QUARTER`);
  - coin values 5/10/25;
  - the state typedef (IDLE, COLLECT, VEND, RETURN);
  - the default CREDIT_W.
- Sub-module `coin_value_decoder`: combinational, `coin_type` → value in cents, plus a `valid` flag. The dispenser side can reuse it.

## Test plan
- Reset asserted mid-stream → all outputs 0 and `credit` = 0 on the following cycle; the FSM resumes from IDLE.
- Quarter, quarter, dime, then `vend_req` with `price` = 50 → three `coin_accept` pulses with `credit` 25/50/60. Then `vend` for 1 cycle, `change` = 10, and `change_valid` held for 5 cycles until `change_ack`, then IDLE.
- 19 quarters (credit 475), then a quarter → `coin_reject`, `credit` stays 475. Then a nickel → accepted, `credit` = 480. A slug → rejected.
- `credit` = 30, `vend_req` with `price` = 50 → `insufficient` pulse, no `vend`, `credit` = 30.
- `credit` = 35 with `cancel`, `vend_req` (`price` = 25) and a dime all in one cycle → `coin_reject`, no `vend`, `change` = 35, `credit` = 0.
- Exact payment, `credit` = 50 and `price` = 50 → `vend` pulse, `change_valid` never asserts, IDLE. Separately, `rst` asserted during RETURN → `change_valid` drops immediately.
